dense_layer: RTL and testbench
==============================

// Module: dense_layer
// PURPOSE
//   Fully-connected (dense) neural-network layer: OUT_N parallel perceptrons, each computing
//   ReLU(sum_i x_i*w_ji + b_j) over a shared IN_N-element signed input vector. Two-stage
//   pipeline, one new vector accepted per clock. Layers chain by feeding out_vec of one
//   layer into in_vec of the next.
// PARAMETERS
//   IN_N        4   number of input elements
//   OUT_N       8   number of neurons (output elements)
//   DATA_WIDTH  8   signed two's-complement width of inputs, weights, biases, outputs
//   ACC_WIDTH   32  signed accumulator width; must be >= 2*DATA_WIDTH+$clog2(IN_N+1)
// PORTS
//   clk      in   1                       clock; all state updates on rising edge
//   rst      in   1                       synchronous reset, active-high
//   in_vec   in   IN_N*DATA_WIDTH         x_i = in_vec[i*DATA_WIDTH +: DATA_WIDTH]
//   weights  in   OUT_N*IN_N*DATA_WIDTH   w_ji = weights[(j*IN_N+i)*DATA_WIDTH +: DATA_WIDTH]
//   biases   in   OUT_N*DATA_WIDTH        b_j = biases[j*DATA_WIDTH +: DATA_WIDTH]
//   out_vec  out  OUT_N*DATA_WIDTH        y_j = out_vec[j*DATA_WIDTH +: DATA_WIDTH]
// BEHAVIOUR
//   - One clock, one synchronous active-high reset; no handshake, no valid signals.
//     Inputs are sampled every rising edge; the design is fully pipelined.
//   - Stage 1 (edge k): acc_j <= sign_ext(b_j) + sum_i (x_i * w_ji); products are full
//     2*DATA_WIDTH signed, sign-extended to ACC_WIDTH; sum wraps modulo 2^ACC_WIDTH.
//   - Stage 2 (edge k+1): y_j <= (acc_j <= 0) ? 0 :
//     (acc_j > 2^(DATA_WIDTH-1)-1) ? 2^(DATA_WIDTH-1)-1 : acc_j[DATA_WIDTH-1:0].
//     i.e. ReLU, then saturate to the positive signed range; no scaling/shift.
//   - Latency: inputs stable before edge k appear on out_vec after edge k+1 (2 edges).
//     Throughput: 1 vector/cycle; out_vec is a registered output, held between updates.
//   - Each neuron j uses only x, w_j*, b_j; neurons are fully independent.
//   - Reset: while rst=1 at an edge, all stage-1 accumulators and out_vec clear to 0.
//     Reset mid-stream discards all in-flight vectors; the first valid output after
//     release is the vector sampled at the first edge with rst=0, visible one edge later.
//   - Boundary: acc exactly 0 -> 0; acc = 2^(DATA_WIDTH-1)-1 -> passed unchanged;
//     most negative operands (-128*-128) handled as signed full-width products.
//   - Purely combinational input changes between edges have no effect on out_vec.
// TESTING (DATA_WIDTH=8, IN_N=4, OUT_N=8, ACC_WIDTH=32)
//   1. rst=1 for 2 edges with nonzero inputs -> out_vec == 0; stays 0 one edge after release
//      until the first sampled vector propagates.
//   2. x={1,2,3,4}, all w=1, all b=0 -> after 2 edges every y_j == 10.
//   3. x={1,1,1,1}, all w=-1, b=0 -> every y_j == 0 (ReLU of -4); with b=5 -> y_j == 1.
//   4. x=all 127, w=all 127, b=127 (acc=64643) -> y_j == 127; x=all -128, w=all -128
//      (acc=65536) -> y_j == 127.
//   5. Per-neuron independence: x={1,2,3,4}, w_ji = (i==j%4) ? 1 : 0, b_j=10*(j/4)
//      -> y = {1,2,3,4,11,12,13,14}.
//   6. Back-to-back vectors on consecutive edges -> outputs stream one per cycle, each
//      exactly 2 edges after its input; assert rst mid-stream -> out_vec 0, in-flight
//      results never appear.

Source files
------------

// File: rtl/dense_layer.sv
// Fully-connected layer: OUT_N neurons, multiply-accumulate then ReLU with saturation.
// Two registered stages; accepts a new input vector on every clock.
module dense_layer #(
    parameter int IN_N       = 4,
    parameter int OUT_N      = 8,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [IN_N*DATA_WIDTH-1:0]       in_vec,
    input  logic [OUT_N*IN_N*DATA_WIDTH-1:0] weights,
    input  logic [OUT_N*DATA_WIDTH-1:0]      biases,
    output logic [OUT_N*DATA_WIDTH-1:0]      out_vec
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam logic signed [ACC_WIDTH-1:0] YMAX =
        ACC_WIDTH'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);

    logic signed [PW-1:0]        prod  [OUT_N][IN_N];
    logic signed [ACC_WIDTH-1:0] acc_d [OUT_N];
    logic signed [ACC_WIDTH-1:0] acc_q [OUT_N];
    logic [OUT_N*DATA_WIDTH-1:0] out_d;

    // Full-width signed products, so -128 * -128 stays +16384.
    always_comb begin
        for (int j = 0; j < OUT_N; j++) begin
            for (int i = 0; i < IN_N; i++) begin
                prod[j][i] =
                    $signed(in_vec[i*DATA_WIDTH +: DATA_WIDTH]) *
                    $signed(weights[(j*IN_N+i)*DATA_WIDTH +: DATA_WIDTH]);
            end
        end
    end

    always_comb begin
        for (int j = 0; j < OUT_N; j++) begin
            acc_d[j] = ACC_WIDTH'($signed(biases[j*DATA_WIDTH +: DATA_WIDTH]));
            for (int i = 0; i < IN_N; i++) begin
                acc_d[j] = acc_d[j] + ACC_WIDTH'(prod[j][i]);
            end
        end
    end

    // ReLU, then clamp into the positive signed output range.
    always_comb begin
        out_d = '0;
        for (int j = 0; j < OUT_N; j++) begin
            if (acc_q[j] <= 0) begin
                out_d[j*DATA_WIDTH +: DATA_WIDTH] = '0;
            end else if (acc_q[j] > YMAX) begin
                out_d[j*DATA_WIDTH +: DATA_WIDTH] = YMAX[DATA_WIDTH-1:0];
            end else begin
                out_d[j*DATA_WIDTH +: DATA_WIDTH] = acc_q[j][DATA_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < OUT_N; j++) begin
                acc_q[j] <= '0;
            end
            out_vec <= '0;
        end else begin
            for (int j = 0; j < OUT_N; j++) begin
                acc_q[j] <= acc_d[j];
            end
            out_vec <= out_d;
        end
    end

endmodule

// File: tb/tb_dense_layer.sv
// Scoreboard bench for dense_layer: driver queues expected outputs from an
// arithmetic reference model; a negedge monitor pops and compares them.
module tb_dense_layer;

    localparam int IN_N  = 4;
    localparam int OUT_N = 8;
    localparam int DW    = 8;
    localparam int AW    = 32;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic [IN_N*DW-1:0]          in_vec = '0;
    logic [OUT_N*IN_N*DW-1:0]    weights = '0;
    logic [OUT_N*DW-1:0]         biases = '0;
    logic [OUT_N*DW-1:0]         out_vec;

    dense_layer #(
        .IN_N(IN_N), .OUT_N(OUT_N), .DATA_WIDTH(DW), .ACC_WIDTH(AW)
    ) dut (
        .clk(clk), .rst(rst), .in_vec(in_vec), .weights(weights),
        .biases(biases), .out_vec(out_vec)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        logic [OUT_N*DW-1:0] y;
        int                  due;
    } exp_t;

    exp_t sbq[$];

    int xv[IN_N];
    int wv[OUT_N][IN_N];
    int bv[OUT_N];

    int vectors = 0;
    int miscompares = 0;

    function automatic logic [OUT_N*DW-1:0] model();
        logic [OUT_N*DW-1:0] r;
        r = '0;
        for (int j = 0; j < OUT_N; j++) begin
            int s;
            s = bv[j];
            for (int i = 0; i < IN_N; i++) s += xv[i] * wv[j][i];
            if (s < 0) s = 0;
            if (s > 127) s = 127;
            r[j*DW +: DW] = DW'(s);
        end
        return r;
    endfunction

    task automatic pack();
        for (int i = 0; i < IN_N; i++) in_vec[i*DW +: DW] = DW'(xv[i]);
        for (int j = 0; j < OUT_N; j++) begin
            biases[j*DW +: DW] = DW'(bv[j]);
            for (int i = 0; i < IN_N; i++)
                weights[(j*IN_N+i)*DW +: DW] = DW'(wv[j][i]);
        end
    endtask

    task automatic set_all(input int xval, input int wval, input int bval);
        for (int i = 0; i < IN_N; i++) xv[i] = xval;
        for (int j = 0; j < OUT_N; j++) begin
            bv[j] = bval;
            for (int i = 0; i < IN_N; i++) wv[j][i] = wval;
        end
    endtask

    function automatic int rnd8();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    task automatic randomize_vec();
        for (int i = 0; i < IN_N; i++) xv[i] = rnd8();
        for (int j = 0; j < OUT_N; j++) begin
            bv[j] = rnd8();
            for (int i = 0; i < IN_N; i++) wv[j][i] = rnd8();
        end
    endtask

    // Drive one vector for the next edge; junk between edges must not matter.
    task automatic apply(input logic r);
        exp_t e;
        int   k;
        @(posedge clk);
        #1;
        in_vec  = IN_N*DW'($urandom);
        biases  = {$urandom, $urandom};
        #2;
        rst = r;
        pack();
        k = cycle + 1;
        if (r) begin
            while (sbq.size() > 0 && sbq[$].due >= k) void'(sbq.pop_back());
            e.y = '0; e.due = k;     sbq.push_back(e);
            e.y = '0; e.due = k + 1; sbq.push_back(e);
        end else begin
            e.y = model(); e.due = k + 1; sbq.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].due <= cycle) begin
            exp_t e;
            e = sbq.pop_front();
            vectors++;
            if (e.due < cycle) begin
                miscompares++;
                $display("FAIL missed_check due %0d at cycle %0d", e.due, cycle);
            end else if (out_vec !== e.y) begin
                miscompares++;
                $display("FAIL out_vec cycle %0d: got %h, required %h",
                         cycle, out_vec, e.y);
            end
        end
    end

    initial begin
        int t;
        // Reset held for two edges with nonzero inputs.
        set_all(5, 7, 3);
        apply(1'b1);
        apply(1'b1);

        xv = '{1, 2, 3, 4};
        for (int j = 0; j < OUT_N; j++) begin
            bv[j] = 0;
            for (int i = 0; i < IN_N; i++) wv[j][i] = 1;
        end
        apply(1'b0);
        apply(1'b0);

        set_all(1, -1, 0);  apply(1'b0);
        set_all(1, -1, 5);  apply(1'b0);
        set_all(127, 127, 127);   apply(1'b0);
        set_all(-128, -128, 0);   apply(1'b0);
        set_all(0, 0, 0);         apply(1'b0);

        // acc = 127 passes unchanged, acc = 128 saturates.
        set_all(0, 1, 0); xv[0] = 127; apply(1'b0);
        set_all(0, 1, 1); xv[0] = 127; apply(1'b0);

        xv = '{1, 2, 3, 4};
        for (int j = 0; j < OUT_N; j++) begin
            bv[j] = 10 * (j / 4);
            for (int i = 0; i < IN_N; i++) wv[j][i] = (i == j % 4) ? 1 : 0;
        end
        apply(1'b0);

        // Back-to-back random stream with occasional mid-stream resets.
        for (int n = 0; n < 300; n++) begin
            randomize_vec();
            if (n % 8 == 0)
                for (int i = 0; i < IN_N; i++) xv[i] = int'($urandom_range(0, 3));
            apply($urandom_range(0, 19) == 0);
        end
        randomize_vec();
        apply(1'b0);

        t = 0;
        while (sbq.size() > 0 && t < 10) begin
            @(posedge clk);
            t++;
        end
        @(posedge clk);
        if (sbq.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d entries left, required 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
